// File: rtl/int_bit_scan.sv
// int_bit_scan: walks a latched 64-bit operand LSB-first and streams the index
// of every set bit on a valid/ready interface, then pulses done with the
// number of indices emitted. Companion to the set/clear/get bit unit.
module int_bit_scan #(
  parameter int WIDTH = 64,  // operand width, power of 2, multiple of CHUNK
  parameter int CHUNK = 8,   // bits examined per SCAN cycle, power of 2
  parameter int IDX_W = 6    // log2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   count
);

  // Width of a bit position inside one chunk.
  localparam int LSB_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  // Base of the final chunk; reaching it with nothing left ends the scan.
  localparam logic [IDX_W-1:0] LAST_CURSOR = IDX_W'(WIDTH - CHUNK);
  localparam logic [IDX_W-1:0] CURSOR_STEP = IDX_W'(CHUNK);

  // Controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // State and datapath registers with their next-state values.
  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] shadow_q,    shadow_d;
  logic [IDX_W-1:0] cursor_q,    cursor_d;
  logic [IDX_W:0]   count_q,     count_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             out_last_q,  out_last_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;

  // Chunk under the cursor and the position of its lowest set bit.
  logic [CHUNK-1:0] chunk_bits;
  logic             chunk_hit;
  logic [LSB_W-1:0] chunk_lsb;
  logic [IDX_W-1:0] hit_index;
  logic [WIDTH-1:0] hit_mask;
  logic             hit_is_last;
  logic             handshake;

  // Select the chunk currently being examined.
  always_comb begin
    chunk_bits = shadow_q[cursor_q +: CHUNK];
    chunk_hit  = |chunk_bits;
  end

  // Priority-encode the lowest set bit of the chunk; scanning downward lets
  // the lowest match win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    chunk_lsb = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_bits[i]) begin
        chunk_lsb = LSB_W'(i);
      end
    end
  end

  // Absolute index of the hit and whether it is the final set bit.
  always_comb begin
    hit_index            = cursor_q + IDX_W'(chunk_lsb);
    hit_mask             = '0;
    hit_mask[hit_index]  = 1'b1;
    hit_is_last          = ~|(shadow_q & ~hit_mask);
  end

  // An index is consumed when the stream handshakes.
  always_comb begin
    handshake = out_valid_q && out_ready;
  end

  // Next-state logic for the controller and datapath.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    cursor_d    = cursor_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = opa;
          cursor_d = '0;
          count_d  = '0;
          state_d  = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (chunk_hit) begin
          out_index_d = hit_index;
          out_last_d  = hit_is_last;
          out_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else if (cursor_q == LAST_CURSOR) begin
          state_d = ST_DONE;
        end else begin
          cursor_d = cursor_q + CURSOR_STEP;
        end
      end

      ST_EMIT: begin
        // out_index/out_last are untouched here, so they stay stable while
        // the consumer stalls.
        if (handshake) begin
          shadow_d[out_index_q] = 1'b0;
          count_d               = count_q + (IDX_W + 1)'(1);
          out_valid_d           = 1'b0;
          // The cursor is kept: the same chunk may hold further set bits.
          state_d               = out_last_q ? ST_DONE : ST_SCAN;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy follows the state being entered, so it is high through SCAN, EMIT
    // and DONE and drops together with the done pulse.
    busy_d = (state_d != ST_IDLE);
  end

  // Register all state and outputs; synchronous reset aborts any scan.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      cursor_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cursor_q    <= cursor_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Drive ports straight from registers.
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_int_bit_scan.sv
// Self-checking bench for int_bit_scan: table-driven scans with a scoreboard
// of expected indices, plus hand-written stall and reset-abort sequences.
module tb_int_bit_scan;

  localparam int WIDTH = 64;
  localparam int CHUNK = 8;
  localparam int IDX_W = 6;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] opa;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             done;
  logic [IDX_W:0]   count;

  int checks = 0;
  int failures = 0;

  // 0: ready always high, 1: toggles each cycle, 2: random, 3: driven by test
  int ready_mode = 3;

  int exp_q[$];

  typedef struct {
    string       name;
    logic [63:0] vec_opa;
    int          mode;
    bit          restart;
    int          exp_count;
    int          exp_first_lat;  // -1: no index expected
    int          exp_done_lat;   // -1: not checked
  } vec_t;

  int_bit_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opa       (opa),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready generation, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Scoreboard monitor: pops on every handshake, checks stability on stalls.
  logic [IDX_W-1:0] held_idx;
  logic             held_last;
  bit               stalled = 0;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_index", out_index, held_idx);
        check("hold_last",  out_last,  held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_index", out_index, 64'hFFFF);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("index", out_index, e);
          check("last",  out_last,  exp_q.size() == 0);
        end
        stalled = 0;
      end else if (out_valid) begin
        stalled   = 1;
        held_idx  = out_index;
        held_last = out_last;
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_done"},      done,      0);
    check({tag, "_count"},     count,     0);
  endtask

  // Pulse start for one edge and return just after that edge; opa is then
  // scrambled so a design that keeps reading it would be caught.
  task automatic pulse_start(input logic [63:0] v);
    @(negedge clk);
    opa   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opa   = ~v;
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  seen_valid;
    bit  got_done;
    ready_mode = v.mode;
    for (int i = 0; i < WIDTH; i++) begin
      if (v.vec_opa[i]) exp_q.push_back(i);
    end
    pulse_start(v.vec_opa);
    cyc = 0;
    seen_valid = 0;
    got_done = 0;
    while (!got_done && cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check({v.name, "_busy_running"}, busy, 1);
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        if (v.exp_first_lat >= 0)
          check({v.name, "_first_valid_latency"}, cyc, v.exp_first_lat);
      end
      if (v.restart && cyc == 2) begin
        start = 1'b1;
        opa   = 64'hFFFF_0000_FFFF_0000;
      end
      if (v.restart && cyc == 3) start = 1'b0;
      if (done) begin
        got_done = 1;
        check({v.name, "_count"}, count, v.exp_count);
        if (v.exp_done_lat >= 0) check({v.name, "_done_latency"}, cyc, v.exp_done_lat);
      end
    end
    if (!got_done) check({v.name, "_done_timeout"}, 0, 1);
    check({v.name, "_any_valid"}, seen_valid, v.exp_count > 0);
    check({v.name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check({v.name, "_done_one_cycle"}, done, 0);
    check({v.name, "_busy_after"},     busy, 0);
    check({v.name, "_count_holds"},    count, v.exp_count);
  endtask

  vec_t vecs[8];

  initial begin
    int  cyc;
    bit  saw_done;

    vecs[0] = '{"zero",      64'h0,                    0, 0, 0,  -1, 9};
    vecs[1] = '{"ends",      64'h8000_0000_0000_0001,  0, 0, 2,  1,  -1};
    vecs[2] = '{"ones_tog",  64'hFFFF_FFFF_FFFF_FFFF,  1, 0, 64, 1,  -1};
    vecs[3] = '{"bit40",     64'h0000_0100_0000_0000,  0, 0, 1,  6,  -1};
    vecs[4] = '{"mixed_rnd", 64'h00F0_0000_0000_0F00,  2, 0, 8,  2,  -1};
    vecs[5] = '{"restart",   64'h0000_0000_8000_0000,  0, 1, 1,  4,  -1};
    vecs[6] = '{"alt_rnd",   64'h5555_5555_5555_5555,  2, 0, 32, 1,  -1};
    vecs[7] = '{"top_only",  64'h8000_0000_0000_0000,  0, 0, 1,  8,  -1};

    reset = 1'b1;
    start = 1'b0;
    opa = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall: index 40 held for five cycles, accepted on first ready, done next.
    ready_mode = 3;
    out_ready  = 1'b0;
    exp_q.push_back(40);
    pulse_start(64'h0000_0100_0000_0000);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("stall_valid_latency", cyc, 6);
    repeat (4) begin
      @(negedge clk);
      check("stall_valid_held", out_valid, 1);
      check("stall_index_held", out_index, 40);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_valid_dropped", out_valid, 0);
    check("stall_no_early_done", done, 0);
    @(negedge clk);
    check("stall_done", done, 1);
    check("stall_count", count, 1);
    check("stall_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while in EMIT aborts the scan without a done pulse.
    pulse_start(64'h0000_0000_0000_0310);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("abort_reached_emit", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    exp_q.delete();
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);

    run_vec('{"after_abort", 64'h0000_0000_0000_0310, 0, 0, 3, 1, -1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
